// File: rtl/adder_measure_sequencer_if.sv
// Control/result and adder-side signals of one measurement sequencer.
// master is the sequencer; slave is the register block plus the wrapped adder.
interface adder_measure_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [CNT_W-1:0] run_cycles;
  logic [31:0]      adder_sum;
  logic [31:0]      adder_count;
  logic [31:0]      adder_a;
  logic [31:0]      adder_b;
  logic             adder_run;
  logic             adder_counter_rst;
  logic             busy;
  logic             done;
  logic [31:0]      result_sum;
  logic [31:0]      result_count;
  logic             sum_ok;

  modport master (
    input  start, abort, op_a, op_b, run_cycles, adder_sum, adder_count,
    output adder_a, adder_b, adder_run, adder_counter_rst,
    output busy, done, result_sum, result_count, sum_ok
  );

  modport slave (
    output start, abort, op_a, op_b, run_cycles, adder_sum, adder_count,
    input  adder_a, adder_b, adder_run, adder_counter_rst,
    input  busy, done, result_sum, result_count, sum_ok
  );
endinterface

// File: rtl/adder_measure_sequencer.sv
// Sequences one instrumented-adder measurement: load, run window, settle, capture, check.
// done pulses N+SETTLE_CYCLES+2 edges after start; start ignored while busy, abort cancels.
module adder_measure_sequencer #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  adder_measure_sequencer_if.master   bus
);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] run_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      exp_sum;
  logic             sum_match;
  logic             done_q;
  logic [31:0]      res_sum_q;
  logic [31:0]      res_count_q;
  logic             sum_ok_q;

  // 32-bit add drops the carry, giving the mod 2^32 expected sum.
  assign exp_sum   = a_q + b_q;
  assign sum_match = (bus.adder_sum == exp_sum);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      run_cnt     <= '0;
      settle_cnt  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      done_q      <= 1'b0;
      res_sum_q   <= '0;
      res_count_q <= '0;
      sum_ok_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start && !bus.abort) begin
              a_q     <= bus.op_a;
              b_q     <= bus.op_b;
              run_cnt <= (bus.run_cycles == '0) ? CNT_W'(1) : bus.run_cycles;
              state   <= ST_LOAD;
            end
          end
          ST_LOAD: state <= ST_RUN;
          ST_RUN: begin
            if (run_cnt == CNT_W'(1)) begin
              settle_cnt <= SET_W'(SETTLE_CYCLES);
              state      <= ST_SETTLE;
            end else begin
              run_cnt <= run_cnt - CNT_W'(1);
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SET_W'(1)) state <= ST_CAPTURE;
            else settle_cnt <= settle_cnt - SET_W'(1);
          end
          ST_CAPTURE: begin
            res_sum_q   <= bus.adder_sum;
            res_count_q <= bus.adder_count;
            sum_ok_q    <= sum_match;
            done_q      <= 1'b1;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Decoded straight from the async-reset state so adder_run drops with reset.
  assign bus.adder_run         = (state == ST_RUN);
  assign bus.adder_counter_rst = (state == ST_LOAD);
  assign bus.busy              = (state != ST_IDLE);
  assign bus.adder_a           = a_q;
  assign bus.adder_b           = b_q;
  assign bus.done              = done_q;
  assign bus.result_sum        = res_sum_q;
  assign bus.result_count      = res_count_q;
  assign bus.sum_ok            = sum_ok_q;
endmodule
